// File: rtl/bpm_tracker.sv
// Beat-interval tempo tracker: averages AVG_DEPTH beat intervals and divides 60*CLOCK_FREQ by the mean.
// Optional macro BPM_TRACKER_TIMEOUT_EN drops lock and clears the tempo when beats stop arriving.
module bpm_tracker #(
    parameter int BPM_WIDTH  = 16,
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int AVG_DEPTH  = 4,
    parameter int MIN_BPM    = 40,
    parameter int MAX_BPM    = 240
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 beat_pulse,
    output logic [BPM_WIDTH-1:0] bpm_val,
    output logic                 bpm_valid,
    output logic                 locked,
    output logic                 busy
);

    localparam longint unsigned DIVIDEND_L   = 64'd60 * 64'(CLOCK_FREQ);
    localparam logic [31:0]     DIVIDEND     = 32'(DIVIDEND_L);
    localparam logic [31:0]     MIN_INTERVAL = 32'(DIVIDEND_L / 64'(MAX_BPM));
    localparam logic [31:0]     MAX_INTERVAL = 32'(DIVIDEND_L / 64'(MIN_BPM));
    localparam int              PTR_W        = $clog2(AVG_DEPTH);
    localparam int              SUM_W        = 32 + PTR_W;
    localparam logic [PTR_W:0]  FULL         = (PTR_W + 1)'(AVG_DEPTH);
    localparam longint unsigned BPM_MAX      = (64'd1 << BPM_WIDTH) - 64'd1;

    typedef enum logic [1:0] {IDLE, TRACK, DIVIDE} state_t;

    state_t             state;
    logic [31:0]        cnt;
    logic [31:0]        interval;
    logic [31:0]        ring [AVG_DEPTH];
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   sum_next;
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W:0]     fill;
    logic [PTR_W:0]     fill_inc;
    logic [5:0]         div_cnt;
    logic [31:0]        divisor;
    logic [31:0]        quo;
    logic [31:0]        rem;
    logic [32:0]        rem_sh;
    logic [31:0]        rem_sub;
    logic [BPM_WIDTH-1:0] result;
    logic               too_short;
    logic               too_long;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [BPM_WIDTH-1:0] sat_bpm(input logic [31:0] q);
        return ({32'd0, q} > BPM_MAX) ? '1 : BPM_WIDTH'(q);
    endfunction

    // The counter is cleared to 0 on a reference beat, so the interval seen at a beat is cnt+1.
    always_comb begin
        interval  = sat_inc(cnt);
        too_short = interval < MIN_INTERVAL;
        too_long  = interval > MAX_INTERVAL;
        sum_next  = sum + {{PTR_W{1'b0}}, interval} - {{PTR_W{1'b0}}, ring[wptr]};
        fill_inc  = (fill == FULL) ? fill : fill + 1'b1;
        rem_sh    = {rem, quo[31]};
        rem_sub   = rem_sh[31:0] - divisor;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sum       <= '0;
            wptr      <= '0;
            fill      <= '0;
            div_cnt   <= '0;
            divisor   <= '0;
            quo       <= '0;
            rem       <= '0;
            result    <= '0;
            bpm_val   <= '0;
            bpm_valid <= 1'b0;
            locked    <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < AVG_DEPTH; i++) ring[i] <= '0;
        end else begin
            bpm_valid <= 1'b0;
            cnt       <= sat_inc(cnt);
            case (state)
                IDLE: begin
                    if (beat_pulse) begin
                        cnt   <= '0;
                        state <= TRACK;
                    end
                end
                TRACK: begin
                    if (beat_pulse && !too_short) begin
                        cnt <= '0;
                        if (too_long) begin
                            sum    <= '0;
                            wptr   <= '0;
                            fill   <= '0;
                            locked <= 1'b0;
                            for (int i = 0; i < AVG_DEPTH; i++) ring[i] <= '0;
                        end else begin
                            ring[wptr] <= interval;
                            sum        <= sum_next;
                            wptr       <= wptr + 1'b1;
                            fill       <= fill_inc;
                            if (fill_inc == FULL) begin
                                locked  <= 1'b1;
                                busy    <= 1'b1;
                                div_cnt <= '0;
                                state   <= DIVIDE;
                            end
                        end
                    end
`ifdef BPM_TRACKER_TIMEOUT_EN
                    else if (too_long) begin
                        sum     <= '0;
                        wptr    <= '0;
                        fill    <= '0;
                        locked  <= 1'b0;
                        bpm_val <= '0;
                        state   <= IDLE;
                        for (int i = 0; i < AVG_DEPTH; i++) ring[i] <= '0;
                    end
`endif
                end
                DIVIDE: begin
                    // Step 0 loads, 1..32 iterate, 33 saturates, 34 commits: 35 cycles after the beat.
                    div_cnt <= div_cnt + 6'd1;
                    if (div_cnt == 6'd0) begin
                        divisor <= 32'(sum >> PTR_W);
                        quo     <= DIVIDEND;
                        rem     <= '0;
                    end else if (div_cnt <= 6'd32) begin
                        if (rem_sh >= {1'b0, divisor}) begin
                            rem <= rem_sub;
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= rem_sh[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                    end else if (div_cnt == 6'd33) begin
                        result <= sat_bpm(quo);
                    end else begin
                        bpm_val   <= result;
                        bpm_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= TRACK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bpm_tracker.sv
// Directed bench for bpm_tracker at CLOCK_FREQ=1000 (interval window 250..1500 cycles).
module tb_bpm_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        beat_pulse = 1'b0;
    logic [15:0] bpm_val;
    logic        bpm_valid;
    logic        locked;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int since = 0;
    logic seen_valid;

    bpm_tracker #(
        .BPM_WIDTH (16),
        .CLOCK_FREQ(1000),
        .AVG_DEPTH (4),
        .MIN_BPM   (40),
        .MAX_BPM   (240)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .beat_pulse(beat_pulse),
        .bpm_val   (bpm_val),
        .bpm_valid (bpm_valid),
        .locked    (locked),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        since++;
    endtask

    // Beat sampled on the edge 'gap' cycles after the last accepted beat.
    task automatic beat_in(input int gap, input bit accepted);
        repeat (gap - since - 1) step();
        beat_pulse = 1'b1;
        step();
        beat_pulse = 1'b0;
        if (accepted) since = 0;
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] exp);
        repeat (34) step();
        chk({tag, "_early"}, 32'(bpm_valid), 32'd0);
        step();
        chk({tag, "_valid"}, 32'(bpm_valid), 32'd1);
        chk({tag, "_bpm"}, 32'(bpm_val), exp);
        step();
        chk({tag, "_pulse"}, 32'(bpm_valid), 32'd0);
    endtask

    task automatic do_reset(input bit with_beat);
        reset = 1'b1;
        beat_pulse = with_beat;
        step();
        reset = 1'b0;
        beat_pulse = 1'b0;
        since = 0;
    endtask

    initial begin
        #1;
        do_reset(1'b0);
        step();
        chk("rst_bpm", 32'(bpm_val), 32'd0);
        chk("rst_valid", 32'(bpm_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Five beats 500 apart
        beat_in(1, 1'b1);
        beat_in(500, 1'b1);
        beat_in(500, 1'b1);
        beat_in(500, 1'b1);
        chk("fill3_locked", 32'(locked), 32'd0);
        chk("fill3_busy", 32'(busy), 32'd0);
        beat_in(500, 1'b1);
        chk("fill4_locked", 32'(locked), 32'd1);
        chk("fill4_busy", 32'(busy), 32'd1);
        wait_valid("lock500", 32'd120);
        chk("idle_busy", 32'(busy), 32'd0);

        // Debounce: beat 100 cycles after a beat is ignored
        beat_in(100, 1'b0);
        chk("short_busy", 32'(busy), 32'd0);
        chk("short_locked", 32'(locked), 32'd1);
        beat_in(500, 1'b1);
        wait_valid("after_short", 32'd120);

        // Intervals 400,400,600,600 then 250
        beat_in(400, 1'b1);
        wait_valid("i400a", 32'd126);
        beat_in(400, 1'b1);
        wait_valid("i400b", 32'd133);
        beat_in(600, 1'b1);
        wait_valid("i600a", 32'd126);
        beat_in(600, 1'b1);
        wait_valid("i600b", 32'd120);
        beat_in(250, 1'b1);
        wait_valid("i250", 32'd129);

        // Boundaries: 249 ignored, 250 accepted, 1500 accepted, 1501 unlocks
        beat_in(249, 1'b0);
        chk("b249_busy", 32'(busy), 32'd0);
        beat_in(250, 1'b1);
        chk("b250_busy", 32'(busy), 32'd1);
        wait_valid("b250", 32'd141);
        beat_in(1500, 1'b1);
        wait_valid("b1500a", 32'd92);
        beat_in(1500, 1'b1);
        wait_valid("b1500b", 32'd68);
        beat_in(1500, 1'b1);
        wait_valid("b1500c", 32'd50);
        beat_in(1500, 1'b1);
        wait_valid("b1500d", 32'd40);
        beat_in(1501, 1'b1);
        chk("b1501_locked", 32'(locked), 32'd0);
        chk("b1501_busy", 32'(busy), 32'd0);
        chk("b1501_bpm", 32'(bpm_val), 32'd40);

        // Buffer was cleared: relock needs four fresh intervals
        beat_in(500, 1'b1);
        beat_in(500, 1'b1);
        beat_in(500, 1'b1);
        chk("relock3_locked", 32'(locked), 32'd0);
        chk("relock3_busy", 32'(busy), 32'd0);
        beat_in(500, 1'b1);
        chk("relock4_locked", 32'(locked), 32'd1);
        wait_valid("relock", 32'd120);

        // No beats for 1501 cycles
        repeat (1500 - since) step();
        chk("to1500_locked", 32'(locked), 32'd1);
        chk("to1500_bpm", 32'(bpm_val), 32'd120);
        step();
`ifdef BPM_TRACKER_TIMEOUT_EN
        chk("to1501_locked", 32'(locked), 32'd0);
        chk("to1501_bpm", 32'(bpm_val), 32'd0);
`else
        chk("to1501_locked", 32'(locked), 32'd1);
        chk("to1501_bpm", 32'(bpm_val), 32'd120);
`endif
        chk("to1501_valid", 32'(bpm_valid), 32'd0);

        // Reset (with a coincident beat) 10 cycles into DIVIDE
        beat_in(1600, 1'b1);
`ifndef BPM_TRACKER_TIMEOUT_EN
        chk("long_ref_locked", 32'(locked), 32'd0);
        chk("long_ref_bpm", 32'(bpm_val), 32'd120);
`endif
        beat_in(500, 1'b1);
        beat_in(500, 1'b1);
        beat_in(500, 1'b1);
        beat_in(500, 1'b1);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        repeat (11) step();
        do_reset(1'b1);
        chk("abort_bpm", 32'(bpm_val), 32'd0);
        chk("abort_valid", 32'(bpm_valid), 32'd0);
        chk("abort_locked", 32'(locked), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        seen_valid = 1'b0;
        repeat (40) begin
            step();
            seen_valid = seen_valid | bpm_valid;
        end
        chk("abort_no_valid", 32'(seen_valid), 32'd0);

        // Coincident beat must not have been a reference: five beats needed to lock
        beat_in(500, 1'b1);
        beat_in(500, 1'b1);
        beat_in(500, 1'b1);
        beat_in(500, 1'b1);
        chk("post_rst4_locked", 32'(locked), 32'd0);
        beat_in(500, 1'b1);
        chk("post_rst5_locked", 32'(locked), 32'd1);
        wait_valid("post_rst", 32'd120);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bpm_tracker.md
BPM_TRACKER -- requirements
Module: bpm_tracker

Interface
REQ-001 Parameter BPM_WIDTH, default 16: width of the bpm_val output.
REQ-002 Parameter CLOCK_FREQ, default 50_000_000: clk frequency in Hz; 60*CLOCK_FREQ SHALL fit in 32 bits unsigned.
REQ-003 Parameter AVG_DEPTH, default 4: number of intervals averaged; SHALL be a power of two, 2..16.
REQ-004 Parameter MIN_BPM, default 40: slowest accepted tempo; sets MAX_INTERVAL = 60*CLOCK_FREQ/MIN_BPM cycles.
REQ-005 Parameter MAX_BPM, default 240: fastest accepted tempo; sets MIN_INTERVAL = 60*CLOCK_FREQ/MAX_BPM cycles; SHALL satisfy MIN_INTERVAL > 40.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 beat_pulse  input  1  one-cycle beat strobe, sampled every cycle.
REQ-009 bpm_val  output  BPM_WIDTH  latest averaged tempo in BPM, unsigned integer.
REQ-010 bpm_valid  output  1  one-cycle strobe when bpm_val updates.
REQ-011 locked  output  1  high once AVG_DEPTH consecutive accepted intervals are buffered.
REQ-012 busy  output  1  high while the divider runs.

Function
REQ-013 States: IDLE (no reference beat), TRACK (measuring), DIVIDE (computing).
REQ-014 Interval counter: 32-bit, counts cycles since the last accepted beat, saturates at all-ones; interval = cycle-index difference between two beats.
REQ-015 IDLE + beat_pulse: record reference beat, clear counter, go to TRACK; no interval stored.
REQ-016 TRACK + beat with interval < MIN_INTERVAL: beat ignored, counter not cleared (debounce).
REQ-017 TRACK + beat with MIN_INTERVAL <= interval <= MAX_INTERVAL: interval written to ring buffer at write pointer, running sum updated (sum += new - evicted), pointer wraps modulo AVG_DEPTH, fill count saturates at AVG_DEPTH, counter cleared.
REQ-018 TRACK + beat with interval > MAX_INTERVAL: ring buffer, sum, fill count cleared; locked -> 0; beat becomes new reference; bpm_val retained.
REQ-019 Accepted beat when fill count reaches AVG_DEPTH: locked -> 1, enter DIVIDE the cycle after; fill below AVG_DEPTH: no division.
REQ-020 Average = sum >> log2(AVG_DEPTH), truncated; sum register wide enough for AVG_DEPTH*32-bit values without overflow.
REQ-021 DIVIDE: 32-iteration restoring divider, 60*CLOCK_FREQ / average, quotient truncated; busy high throughout.
REQ-022 Latency: bpm_val updated and bpm_valid pulsed exactly 35 cycles after the accepted beat cycle; then return to TRACK.
REQ-023 Quotient > 2^BPM_WIDTH-1: bpm_val saturates to all-ones.
REQ-024 Beats during DIVIDE: counter keeps running, beats evaluated per REQ-016..018 on return (guaranteed short by REQ-005, so ignored).
REQ-025 bpm_valid never asserts while locked is 0.

Reset
REQ-026 reset high on a clk edge: state IDLE, counter, buffer, sum, pointer, fill count cleared; bpm_val=0, bpm_valid=0, locked=0, busy=0 the following cycle.
REQ-027 reset during DIVIDE aborts the division; no bpm_valid pulse is produced.
REQ-028 reset dominates a simultaneous beat_pulse.

Configuration
REQ-029 Macro BPM_TRACKER_TIMEOUT_EN: when defined, counter exceeding MAX_INTERVAL in TRACK forces IDLE, clears buffer/fill, locked=0, bpm_val=0, with no bpm_valid pulse.
REQ-030 Without BPM_TRACKER_TIMEOUT_EN: no timeout; bpm_val and locked hold until the next out-of-range beat (REQ-018) or reset.

Verification (CLOCK_FREQ=1000, AVG_DEPTH=4, MIN_BPM=40, MAX_BPM=240: MIN_INTERVAL=250, MAX_INTERVAL=1500)
REQ-031 Five beats 500 cycles apart -> locked=1 at 5th beat, bpm_valid 35 cycles later, bpm_val=120.
REQ-032 Intervals 400,400,600,600 -> average 500, bpm_val=120; next interval 250 -> average 462, bpm_val=129.
REQ-033 Locked at 120, extra beat 100 cycles after a beat -> ignored, next beat 500 after original gives bpm_val=120.
REQ-034 Intervals of 249 ignored; 250 accepted; 1500 accepted (four of 1500 -> bpm_val=40); 1501 -> locked=0, buffer cleared.
REQ-035 With BPM_TRACKER_TIMEOUT_EN, locked at 120, no beats -> 1501 cycles after last beat locked=0, bpm_val=0; without macro bpm_val stays 120.
REQ-036 reset asserted 10 cycles into DIVIDE -> next cycle all outputs 0, no bpm_valid pulse, state IDLE.
